// File: rtl/cgia_pkg.sv
// Shared CGIA definitions: bus arbiter state encodings and default timeout.
package cgia_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_VID   = 2'd1,
      ARB_CPU   = 2'd2,
      ARB_ABORT = 2'd3
   } arb_state_t;

   localparam int CPU_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/cgia_bus_arbiter.sv
// Two-master Wishbone arbiter for video memory: the fetcher has fixed priority,
// and a CPU cycle that stalls video for too long is aborted with ERR.
module cgia_bus_arbiter
   import cgia_pkg::*;
#(
   parameter int CPU_TIMEOUT = CPU_TIMEOUT_DEFAULT,
   parameter int TW          = 5
) (
   input  logic        clk_i,
   input  logic        reset_i,

   input  logic        vid_cyc_i,
   input  logic [22:0] vid_adr_i,
   output logic        vid_ack_o,
   output logic [15:0] vid_dat_o,

   input  logic        cpu_cyc_i,
   input  logic        cpu_stb_i,
   input  logic        cpu_we_i,
   input  logic [1:0]  cpu_sel_i,
   input  logic [22:0] cpu_adr_i,
   input  logic [15:0] cpu_dat_i,
   output logic        cpu_ack_o,
   output logic        cpu_err_o,
   output logic [15:0] cpu_dat_o,

   output logic        mem_cyc_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   output logic [1:0]  mem_sel_o,
   output logic [22:0] mem_adr_o,
   output logic [15:0] mem_dat_o,
   input  logic        mem_ack_i,
   input  logic [15:0] mem_dat_i
);

   localparam logic [TW-1:0] TIMEOUT_W = TW'(CPU_TIMEOUT);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [TW-1:0] wait_cnt;
   logic          timeout_hit;

   // The counter saturates at the limit so that an ack landing on the limit
   // cycle leaves the abort armed for the following cycle.
   assign timeout_hit = (CPU_TIMEOUT != 0) && (wait_cnt == TIMEOUT_W);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= ARB_IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state != ARB_CPU && state_nxt == ARB_CPU)
            wait_cnt <= '0;
         else if (state == ARB_CPU && vid_cyc_i && wait_cnt != TIMEOUT_W)
            wait_cnt <= wait_cnt + TW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      mem_cyc_o = 1'b0;
      mem_stb_o = 1'b0;
      mem_we_o  = 1'b0;
      mem_sel_o = 2'b00;
      mem_adr_o = '0;
      vid_ack_o = 1'b0;
      cpu_ack_o = 1'b0;
      cpu_err_o = 1'b0;

      unique case (state)
         ARB_IDLE: begin
            if (vid_cyc_i)
               state_nxt = ARB_VID;
            else if (cpu_cyc_i)
               state_nxt = ARB_CPU;
         end
         ARB_VID: begin
            mem_cyc_o = vid_cyc_i;
            mem_stb_o = vid_cyc_i;
            mem_sel_o = 2'b11;
            mem_adr_o = vid_adr_i;
            vid_ack_o = mem_ack_i;
            if (!vid_cyc_i)
               state_nxt = cpu_cyc_i ? ARB_CPU : ARB_IDLE;
         end
         ARB_CPU: begin
            mem_cyc_o = cpu_cyc_i;
            mem_stb_o = cpu_stb_i;
            mem_we_o  = cpu_we_i;
            mem_sel_o = cpu_sel_i;
            mem_adr_o = cpu_adr_i;
            cpu_ack_o = mem_ack_i;
            if (!cpu_cyc_i)
               state_nxt = vid_cyc_i ? ARB_VID : ARB_IDLE;
            else if (timeout_hit && !mem_ack_i)
               state_nxt = ARB_ABORT;
         end
         ARB_ABORT: begin
            cpu_err_o = 1'b1;
            state_nxt = vid_cyc_i ? ARB_VID : ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   assign mem_dat_o = cpu_dat_i;
   assign vid_dat_o = mem_dat_i;
   assign cpu_dat_o = mem_dat_i;

endmodule
